// File: rtl/game_menu_ctrl_pkg.sv
// Shared types and helpers for the game menu controller.
// Holds the FSM state encoding and the index-width rule.
package game_menu_pkg;

    typedef enum logic [2:0] {
        MENU       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_FRAME = 3'd2,
        PLAY       = 3'd3,
        EXIT_WAIT  = 3'd4
    } state_t;

    localparam int SRC_MENU = 0;

    // A single game index still needs one bit of storage.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/game_menu_ctrl_if.sv
// Button/frame inputs and game/video control outputs of the menu controller.
// The master side drives buttons and timing; the slave side is the controller.
interface game_menu_ctrl_if
    import game_menu_pkg::*;
#(
    parameter int N_GAMES = 4
) ();
    localparam int IDX_W = clog2_min1(N_GAMES);

    logic               btn_up;
    logic               btn_down;
    logic               btn_select;
    logic               btn_home;
    logic [N_GAMES-1:0] game_avail;
    logic               frame_tick;
    logic [IDX_W-1:0]   cursor;
    logic [IDX_W-1:0]   active_game;
    logic               in_game;
    logic [N_GAMES-1:0] game_en;
    logic [N_GAMES-1:0] game_rst;
    logic [IDX_W:0]     src_sel;

    modport master (
        output btn_up, btn_down, btn_select, btn_home, game_avail, frame_tick,
        input  cursor, active_game, in_game, game_en, game_rst, src_sel
    );

    modport slave (
        input  btn_up, btn_down, btn_select, btn_home, game_avail, frame_tick,
        output cursor, active_game, in_game, game_en, game_rst, src_sel
    );
endinterface

// File: rtl/game_menu_ctrl_next_avail.sv
// Circular search for the nearest available game from the current index.
// Wraps modulo N_GAMES; returns the current index when nothing else is available.
module menu_next_avail #(
    parameter int N_GAMES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [IDX_W-1:0]   i_cur,
    input  logic [N_GAMES-1:0] i_avail,
    input  logic               i_dir_up,
    output logic [IDX_W-1:0]   o_next,
    output logic               o_found
);

    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] cur,
                                                  input int k, input logic up);
        int t;
        t = up ? (int'(cur) + N_GAMES - k) : (int'(cur) + k);
        return IDX_W'(t % N_GAMES);
    endfunction

    // Walk from the farthest distance inward so the nearest hit wins.
    always_comb begin
        o_next  = i_cur;
        o_found = 1'b0;
        for (int k = N_GAMES - 1; k >= 1; k--) begin
            if (i_avail[step_idx(i_cur, k, i_dir_up)]) begin
                o_next  = step_idx(i_cur, k, i_dir_up);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_menu_ctrl.sv
// Console menu controller: cursor navigation, timed game reset on launch,
// and frame-aligned switching of the video source into and out of a game.
module game_menu_ctrl
    import game_menu_pkg::*;
#(
    parameter int N_GAMES    = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic            clk_100,
    input  logic            reset,
    game_menu_ctrl_if.slave bus
);
    localparam int IDX_W = clog2_min1(N_GAMES);
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_cursor;
    logic [IDX_W-1:0]   r_active;
    logic [CNT_W-1:0]   r_rst_cnt;
    logic               r_up_q, r_down_q, r_sel_q, r_home_q;
    logic               r_in_game;
    logic [N_GAMES-1:0] r_game_en;
    logic [N_GAMES-1:0] r_game_rst;
    logic [IDX_W:0]     r_src_sel;

    logic               w_press_up, w_press_down, w_press_sel, w_press_home;
    logic               w_nav;
    logic               w_found;
    logic [IDX_W-1:0]   w_next_idx;
    logic [N_GAMES-1:0] w_active_oh;

    assign w_press_up   = bus.btn_up     & ~r_up_q;
    assign w_press_down = bus.btn_down   & ~r_down_q;
    assign w_press_sel  = bus.btn_select & ~r_sel_q;
    assign w_press_home = bus.btn_home   & ~r_home_q;
    // Simultaneous up and down cancel each other.
    assign w_nav        = w_press_up ^ w_press_down;
    assign w_active_oh  = N_GAMES'(1) << r_active;

    menu_next_avail #(
        .N_GAMES (N_GAMES),
        .IDX_W   (IDX_W)
    ) u_next_avail (
        .i_cur    (r_cursor),
        .i_avail  (bus.game_avail),
        .i_dir_up (w_press_up),
        .o_next   (w_next_idx),
        .o_found  (w_found)
    );

    // Outputs are updated on the transitions that change them, so every
    // output is a register aligned with r_state.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            r_state    <= MENU;
            r_cursor   <= '0;
            r_active   <= '0;
            r_rst_cnt  <= '0;
            r_up_q     <= 1'b0;
            r_down_q   <= 1'b0;
            r_sel_q    <= 1'b0;
            r_home_q   <= 1'b0;
            r_in_game  <= 1'b0;
            r_game_en  <= '0;
            r_game_rst <= '1;
            r_src_sel  <= (IDX_W+1)'(SRC_MENU);
        end else begin
            r_up_q   <= bus.btn_up;
            r_down_q <= bus.btn_down;
            r_sel_q  <= bus.btn_select;
            r_home_q <= bus.btn_home;
            case (r_state)
                MENU: begin
                    if (w_press_sel && bus.game_avail[r_cursor]) begin
                        r_active  <= r_cursor;
                        r_rst_cnt <= CNT_W'(RST_CYCLES - 1);
                        r_state   <= LAUNCH;
                    end else if (w_nav && w_found) begin
                        r_cursor <= w_next_idx;
                    end
                end
                LAUNCH: begin
                    if (w_press_home) begin
                        r_state <= EXIT_WAIT;
                    end else if (r_rst_cnt == '0) begin
                        r_game_rst <= ~w_active_oh;
                        r_state    <= WAIT_FRAME;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - CNT_W'(1);
                    end
                end
                WAIT_FRAME: begin
                    if (w_press_home) begin
                        r_game_rst <= '1;
                        r_state    <= EXIT_WAIT;
                    end else if (bus.frame_tick) begin
                        r_game_en <= w_active_oh;
                        r_in_game <= 1'b1;
                        r_src_sel <= (IDX_W+1)'(r_active) + (IDX_W+1)'(1);
                        r_state   <= PLAY;
                    end
                end
                PLAY: begin
                    // Video keeps showing the game until the exit frame boundary.
                    if (w_press_home) begin
                        r_game_en  <= '0;
                        r_in_game  <= 1'b0;
                        r_game_rst <= '1;
                        r_state    <= EXIT_WAIT;
                    end
                end
                EXIT_WAIT: begin
                    if (bus.frame_tick) begin
                        r_src_sel <= (IDX_W+1)'(SRC_MENU);
                        r_state   <= MENU;
                    end
                end
                default: r_state <= MENU;
            endcase
        end
    end

    assign bus.cursor      = r_cursor;
    assign bus.active_game = r_active;
    assign bus.in_game     = r_in_game;
    assign bus.game_en     = r_game_en;
    assign bus.game_rst    = r_game_rst;
    assign bus.src_sel     = r_src_sel;

endmodule
